// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and 50 MHz default timing for the KEY conditioning blocks.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    // Defaults for a 50 MHz board clock
    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms
    localparam int DEF_CNT_W           = 25;

    // Longest window the shared timer ever has to measure
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous board inputs (KEY/SW), reset value selectable.
module sync_2ff #(
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    // Metastability chain: d -> s1 -> q
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= RESET_VAL;
            q  <= RESET_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: synchronise and debounce one active-low KEY, emit press/release strobes.
// Optional auto-repeat of press_pulse while held: define KEY_AUTOREPEAT_EN.
module key_debounce_pulse
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The timer never needs to count past its longest window, so it parks there instead of wrapping
    localparam logic [CNT_W-1:0] TIMER_CAP =
        CNT_W'(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) - 1);

    logic             s2;
    key_state_e       state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt, timer_inc;
    logic             level_nxt, press_nxt, release_nxt;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    // 0: waiting out the initial delay, 1: in the periodic phase
    logic rep, rep_nxt;
`endif

    sync_2ff #(
        .W         (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (key_n),
        .q     (s2)
    );

    assign timer_inc = (timer >= TIMER_CAP) ? timer : timer + 1'b1;

    // State, timer and all outputs are registered; reset drops any pending strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep           <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            key_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
`ifdef KEY_AUTOREPEAT_EN
            rep           <= rep_nxt;
`endif
        end
    end

    // Next-state: a level change is accepted only after DEBOUNCE_CYCLES consecutive stable samples
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        level_nxt   = key_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_nxt     = rep;
`endif
        case (state)
            IDLE: begin
                if (!s2) begin
                    state_nxt = PRESS_WAIT;
                    timer_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (s2) begin
                    state_nxt = IDLE;
                end else if (timer == DB_LAST) begin
                    state_nxt = HELD;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                    timer_nxt = '0;
`ifdef KEY_AUTOREPEAT_EN
                    rep_nxt   = 1'b0;
`endif
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            HELD: begin
                if (s2) begin
                    state_nxt = RELEASE_WAIT;
                    timer_nxt = '0;
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (timer == (rep ? RPT_PER_LAST : RPT_DLY_LAST)) begin
                    press_nxt = 1'b1;
                    timer_nxt = '0;
                    rep_nxt   = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (!s2) begin
                    // Glitch: back to HELD, repeat window starts over
                    state_nxt = HELD;
                    timer_nxt = '0;
`ifdef KEY_AUTOREPEAT_EN
                    rep_nxt   = 1'b0;
`endif
                end else if (timer == DB_LAST) begin
                    state_nxt   = IDLE;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: directed KEY waveforms; expected strobes/levels queued, checked by a monitor.
module tb_key_debounce_pulse;

    localparam int DB  = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    typedef struct { int c; bit rel; } pulse_t;
    typedef struct { int c; bit lvl; bit prs; bit rel; } lvl_t;

    logic clock = 1'b0;
    logic reset;
    logic key_n;
    logic key_level, press_pulse, release_pulse;

    int     cyc = 0;
    int     checks = 0;
    int     passed = 0;
    bit     done = 1'b0;
    pulse_t pulse_q[$];
    lvl_t   lvl_q[$];
    pulse_t pi;
    lvl_t   li;

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clock = ~clock;

    // cyc = number of the last rising edge
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void pulse_push(input bit rel, input int c);
        pulse_t p;
        p.c = c; p.rel = rel;
        pulse_q.push_back(p);
    endfunction

    function automatic void lvl_push(input int c, input bit lvl, input bit prs, input bit rel);
        lvl_t l;
        l.c = c; l.lvl = lvl; l.prs = prs; l.rel = rel;
        lvl_q.push_back(l);
    endfunction

    // Repeat strobes for a HELD interval entered at 'entry', last HELD edge 'last'
    function automatic void exp_repeats(input int entry, input int last);
        if (AUTOREP)
            for (int t = entry + RD; t <= last; t += RP) pulse_push(1'b0, t);
    endfunction

    // Called at a negedge: key low from the next edge e for 'hold' edges, then released by caller
    task automatic press_hold(input int hold, output int e);
        key_n = 1'b0;
        e = cyc + 1;
        lvl_push(e + DB + 1, 1'b0, 1'b0, 1'b0);
        pulse_push(1'b0, e + DB + 2);
        lvl_push(e + DB + 3, 1'b1, 1'b0, 1'b0);
        exp_repeats(e + DB + 2, e + hold + 1);
        repeat (hold) @(negedge clock);
    endtask

    task automatic release_hold(input int hold, output int r);
        key_n = 1'b1;
        r = cyc + 1;
        lvl_push(r + DB + 1, 1'b1, 1'b0, 1'b0);
        pulse_push(1'b1, r + DB + 2);
        lvl_push(r + DB + 3, 1'b0, 1'b0, 1'b0);
        repeat (hold) @(negedge clock);
    endtask

    // Monitor: pops expectations when strobes appear or a level check comes due
    always @(negedge clock) begin
        if (press_pulse && release_pulse) begin
            checks++;
            $display("FAIL both_strobes: press and release high together at cycle %0d", cyc);
        end
        if (press_pulse || release_pulse) begin
            checks++;
            if (pulse_q.size() == 0) begin
                $display("FAIL unexpected_strobe: %s at cycle %0d, none expected",
                         release_pulse ? "release" : "press", cyc);
            end else begin
                pi = pulse_q.pop_front();
                if (pi.c == cyc && pi.rel == release_pulse && key_level == !pi.rel)
                    passed++;
                else
                    $display("FAIL strobe: got %s cyc %0d level %0b, need %s cyc %0d level %0b",
                             release_pulse ? "release" : "press", cyc, key_level,
                             pi.rel ? "release" : "press", pi.c, !pi.rel);
            end
        end
        while (pulse_q.size() > 0 && pulse_q[0].c < cyc) begin
            pi = pulse_q.pop_front();
            checks++;
            $display("FAIL missed_strobe: got nothing, need %s at cycle %0d",
                     pi.rel ? "release" : "press", pi.c);
        end
        while (lvl_q.size() > 0 && lvl_q[0].c <= cyc) begin
            li = lvl_q.pop_front();
            checks++;
            if (li.c == cyc && key_level == li.lvl && press_pulse == li.prs && release_pulse == li.rel)
                passed++;
            else
                $display("FAIL outputs@%0d: got lvl/prs/rel %0b%0b%0b at cyc %0d, need %0b%0b%0b",
                         li.c, key_level, press_pulse, release_pulse, cyc, li.lvl, li.prs, li.rel);
        end
        if (done) begin
            while (pulse_q.size() > 0) begin
                pi = pulse_q.pop_front();
                checks++;
                $display("FAIL pending_strobe: got nothing, need %s at cycle %0d",
                         pi.rel ? "release" : "press", pi.c);
            end
            while (lvl_q.size() > 0) begin
                li = lvl_q.pop_front();
                checks++;
                $display("FAIL pending_level: got no check, need one at cycle %0d", li.c);
            end
            $display("%0d/%0d checks passed", passed, checks);
            $finish;
        end
    end

    initial begin
        int e, r, g, base;
        reset = 1'b1;
        key_n = 1'b1;
        lvl_push(2, 1'b0, 1'b0, 1'b0);          // reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Clean press, then release
        press_hold(20, e);
        release_hold(12, r);

        // Bounce: low 3 / high 1, five times -> nothing
        base = cyc;
        lvl_push(base + 8, 1'b0, 1'b0, 1'b0);
        lvl_push(base + 19, 1'b0, 1'b0, 1'b0);
        lvl_push(base + 28, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            repeat (3) @(negedge clock);
            key_n = 1'b1;
            @(negedge clock);
        end
        repeat (10) @(negedge clock);

        // Release glitch in HELD: high 2 cycles, then low again
        press_hold(8, e);
        key_n = 1'b1;
        g = cyc + 1;
        repeat (2) @(negedge clock);
        key_n = 1'b0;
        lvl_push(g + 6, 1'b1, 1'b0, 1'b0);
        lvl_push(g + 9, 1'b1, 1'b0, 1'b0);
        exp_repeats(g + 4, g + 2 + 12 + 1);
        repeat (12) @(negedge clock);
        release_hold(12, r);

        // Reset mid-debounce with key still held
        key_n = 1'b0;
        e = cyc + 1;
        lvl_push(e + 3, 1'b0, 1'b0, 1'b0);
        lvl_push(e + 9, 1'b0, 1'b0, 1'b0);
        pulse_push(1'b0, e + 10);
        lvl_push(e + 11, 1'b1, 1'b0, 1'b0);
        exp_repeats(e + 10, e + 21);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (16) @(negedge clock);
        release_hold(12, r);

        // Long hold: single press, or repeats when enabled
        press_hold(30, e);
        release_hold(12, r);

        repeat (5) @(negedge clock);
        done = 1'b1;
    end

endmodule
